dcache_sram_arbiter: RTL



---
 rtl/dcache_sram_arbiter_if.sv | 36 +++
 rtl/dcache_sram_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_arbiter_if.sv
// Shared L1 D-cache SRAM port bundle.
// Requester-side request/grant signals plus the muxed SRAM-side outputs.
interface dcache_sram_arbiter_if #(
    parameter int NR_PORTS   = 6,
    parameter int SET_ASSOC  = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 256,
    parameter int BE_WIDTH   = 64
);
    logic [NR_PORTS-1:0][SET_ASSOC-1:0]  req_i;
    logic [NR_PORTS-1:0]                 we_i;
    logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NR_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NR_PORTS-1:0][BE_WIDTH-1:0]   be_i;
    logic [NR_PORTS-1:0]                 gnt_o;
    logic [NR_PORTS-1:0]                 rvalid_o;
    logic [SET_ASSOC-1:0]                ram_req_o;
    logic                                ram_we_o;
    logic [ADDR_WIDTH-1:0]               ram_addr_o;
    logic [DATA_WIDTH-1:0]               ram_wdata_o;
    logic [BE_WIDTH-1:0]                 ram_be_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o,
        input  ram_req_o, ram_we_o, ram_addr_o,
        input  ram_wdata_o, ram_be_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o,
        output ram_req_o, ram_we_o, ram_addr_o,
        output ram_wdata_o, ram_be_o
    );
endinterface

// File: rtl/dcache_sram_arbiter.sv
// D-cache SRAM port arbiter with power-up / on-demand state-array sweep.
// Fixed priority for miss/snoop, round-robin for core ports, starvation override.
module dcache_sram_arbiter #(
    parameter int NR_PORTS     = 6,
    parameter int SET_ASSOC    = 8,
    parameter int NUM_WORDS    = 256,
    parameter int BYTE_OFFSET  = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 256,
    parameter int BE_WIDTH     = 64,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                init_i,
    output logic                init_done_o,
    output logic [NR_PORTS-1:0] starve_o,
    dcache_sram_arbiter_if.slave bus
);

    localparam int NC    = NR_PORTS - 2;
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int PTR_W = $clog2(NR_PORTS);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W-1:0]    RR_FIRST  = PTR_W'(2);
    localparam logic [PTR_W-1:0]    RR_LAST   = PTR_W'(NR_PORTS - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(STARVE_LIMIT);
    localparam logic [NR_PORTS-1:0] CORE_MASK = ~NR_PORTS'(3);

    typedef enum logic {
        INIT,
        ARB
    } state_t;

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [PTR_W-1:0]                   rr_q, rr_d;
    logic [NR_PORTS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [NR_PORTS-1:0]                rvalid_q, rvalid_d;

    logic [NR_PORTS-1:0] active;
    logic [NR_PORTS-1:0] at_limit;
    logic [NR_PORTS-1:0] starving;
    logic [NR_PORTS-1:0] starve_pick;
    logic [NR_PORTS-1:0] core_pick;
    logic [NR_PORTS-1:0] gnt;
    logic [PTR_W-1:0]    win;
    logic                core_win;

    // First set bit of mask among core ports, scanning upward from ptr and
    // wrapping from the last port back to port 2.
    function automatic logic [NR_PORTS-1:0] rr_pick(
        input logic [NR_PORTS-1:0] mask,
        input logic [PTR_W-1:0]    ptr
    );
        logic [NR_PORTS-1:0] oh;
        int p;
        oh = '0;
        for (int k = 0; k < NC; k++) begin
            p = int'(ptr) + k;
            if (p >= NR_PORTS) p = p - NC;
            if (oh == '0 && mask[p]) oh[p] = 1'b1;
        end
        return oh;
    endfunction

    always_comb begin
        active   = '0;
        at_limit = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            active[p]   = |bus.req_i[p];
            at_limit[p] = (cnt_q[p] == CNT_MAX);
        end
        starving = active & at_limit & CORE_MASK;
    end

    always_comb begin
        starve_pick = rr_pick(starving, rr_q);
        core_pick   = rr_pick(active, rr_q);
        gnt         = '0;
        if (state_q == ARB) begin
            if (|starve_pick) begin
                gnt = starve_pick;
            end else if (active[0]) begin
                gnt[0] = 1'b1;
            end else if (active[1]) begin
                gnt[1] = 1'b1;
            end else begin
                gnt = core_pick;
            end
        end
    end

    always_comb begin
        win = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (gnt[p]) win = PTR_W'(p);
        end
        core_win = |(gnt & CORE_MASK);
    end

    always_comb begin
        bus.ram_req_o   = '0;
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        bus.ram_be_o    = '0;
        if (state_q == INIT) begin
            bus.ram_req_o  = '1;
            bus.ram_we_o   = 1'b1;
            bus.ram_addr_o = ADDR_WIDTH'(idx_q) << BYTE_OFFSET;
            bus.ram_be_o   = '1;
        end else if (|gnt) begin
            bus.ram_req_o   = bus.req_i[win];
            bus.ram_we_o    = bus.we_i[win];
            bus.ram_addr_o  = bus.addr_i[win];
            bus.ram_wdata_o = bus.wdata_i[win];
            bus.ram_be_o    = bus.be_i[win];
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign init_done_o  = (state_q == ARB);
    assign starve_o     = at_limit & CORE_MASK;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        rvalid_d = '0;
        unique case (state_q)
            INIT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ARB;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ARB: begin
                rvalid_d = gnt & ~bus.we_i;
                if (core_win) begin
                    rr_d = (win == RR_LAST) ? RR_FIRST : win + PTR_W'(1);
                end
                for (int p = 2; p < NR_PORTS; p++) begin
                    if (gnt[p] || !active[p]) begin
                        cnt_d[p] = '0;
                    end else if (cnt_q[p] != CNT_MAX) begin
                        cnt_d[p] = cnt_q[p] + CNT_W'(1);
                    end
                end
                // The grant made this cycle still completes; sweep starts next.
                if (init_i) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= INIT;
            idx_q    <= '0;
            rr_q     <= RR_FIRST;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule
